// File: rtl/clk_ctrl.sv
// CPU clock generator: divides clk_in by a selectable half-period H and supports
// free-run, halt and single-step, with divisor changes deferred to a falling edge.
module clk_ctrl #(
  parameter int unsigned SYS_HZ = 50000000,
  parameter int unsigned CNT_W  = 5
) (
  input  logic       clk_in,
  input  logic       reset,
  input  logic       run,
  input  logic       step,
  input  logic [1:0] div_sel,
  input  logic       div_load,
  output logic       clk_out,
  output logic       clk_rise,
  output logic       clk_fall,
  output logic       halted,
  output logic       busy
);

  localparam logic [1:0] ST_HALTED  = 2'd0;
  localparam logic [1:0] ST_RUNNING = 2'd1;
  localparam logic [1:0] ST_STEP    = 2'd2;

  localparam logic [CNT_W-1:0] H_RESET = CNT_W'(5);

  // The half-period table assumes a 50 MHz input and needs room for H=25.
  if (SYS_HZ == 0 || CNT_W < 5) begin : g_bad_cfg
    $error("clk_ctrl: SYS_HZ must be nonzero and CNT_W at least 5");
  end

  function automatic logic [CNT_W-1:0] decode_h(input logic [1:0] sel);
    logic [CNT_W-1:0] h;
    h = CNT_W'(5);
    case (sel)
      2'b00:   h = CNT_W'(5);
      2'b01:   h = CNT_W'(10);
      2'b10:   h = CNT_W'(25);
      default: h = CNT_W'(2);
    endcase
    return h;
  endfunction

  logic [1:0]       state_q,   state_d;
  logic [CNT_W-1:0] count_q,   count_d;
  logic [CNT_W-1:0] h_q,       h_d;
  logic [CNT_W-1:0] pend_q,    pend_d;
  logic             clk_out_q, clk_out_d;
  logic             busy_q,    busy_d;
  logic             rise_q;
  logic             fall_q;
  logic             halted_q;

  logic active_c;
  logic terminal_c;
  logic fall_edge_c;

  // Phase boundary: count reaches H-1 while the clock is being generated.
  assign active_c    = (state_q == ST_RUNNING) || (state_q == ST_STEP);
  assign terminal_c  = active_c && (count_q >= (h_q - CNT_W'(1)));
  assign fall_edge_c = terminal_c && clk_out_q;

  always_ff @(posedge clk_in) begin
    if (!reset) begin
      state_q   <= ST_HALTED;
      count_q   <= '0;
      h_q       <= H_RESET;
      pend_q    <= H_RESET;
      clk_out_q <= 1'b0;
      busy_q    <= 1'b0;
      rise_q    <= 1'b0;
      fall_q    <= 1'b0;
      halted_q  <= 1'b1;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      h_q       <= h_d;
      pend_q    <= pend_d;
      clk_out_q <= clk_out_d;
      busy_q    <= busy_d;
      rise_q    <= clk_out_d & ~clk_out_q;
      fall_q    <= ~clk_out_d & clk_out_q;
      halted_q  <= (state_d == ST_HALTED);
    end
  end

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    clk_out_d = clk_out_q;
    h_d       = h_q;
    pend_d    = pend_q;
    busy_d    = busy_q;

    case (state_q)
      ST_RUNNING, ST_STEP: begin
        if (terminal_c) begin
          count_d   = '0;
          clk_out_d = ~clk_out_q;
          // Halting only on a falling toggle keeps every high phase whole.
          if (fall_edge_c && ((state_q == ST_STEP) || !run)) begin
            state_d = ST_HALTED;
          end
        end else begin
          count_d = count_q + CNT_W'(1);
        end
      end
      default: begin
        count_d   = '0;
        clk_out_d = 1'b0;
        state_d   = ST_HALTED;
        if (run) begin
          state_d = ST_RUNNING;
        end else if (step) begin
          state_d = ST_STEP;
        end
      end
    endcase

    // A fresh load wins over applying the previous pending value on the same edge.
    if (div_load) begin
      pend_d = decode_h(div_sel);
      busy_d = 1'b1;
    end else if (busy_q && (!active_c || fall_edge_c)) begin
      h_d    = pend_q;
      busy_d = 1'b0;
    end
  end

  assign clk_out  = clk_out_q;
  assign clk_rise = rise_q;
  assign clk_fall = fall_q;
  assign halted   = halted_q;
  assign busy     = busy_q;

endmodule

// File: doc/clk_ctrl.md
CLK_CTRL -- requirements
Module: clk_ctrl

Interface
REQ-001 SHALL have parameter SYS_HZ, default 50000000, input clock frequency in Hz (documentation only; the half-period table assumes it).
REQ-002 SHALL have parameter CNT_W, default 5, half-period counter width.
REQ-003 SHALL have port clk_in  input  1  50 MHz system clock; all logic on its rising edge.
REQ-004 SHALL have port reset  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port run  input  1  level; 1 = free-run the CPU clock, 0 = halt.
REQ-006 SHALL have port step  input  1  one-cycle pulse; requests exactly one CPU clock period while halted.
REQ-007 SHALL have port div_sel  input  2  divisor select: 00 H=5 (5 MHz), 01 H=10 (2.5 MHz), 10 H=25 (1 MHz), 11 H=2 (12.5 MHz).
REQ-008 SHALL have port div_load  input  1  one-cycle pulse; captures div_sel as the pending divisor.
REQ-009 SHALL have port clk_out  output  1  generated CPU clock, registered.
REQ-010 SHALL have port clk_rise  output  1  one-cycle pulse, high in the first clk_in cycle in which clk_out is 1.
REQ-011 SHALL have port clk_fall  output  1  one-cycle pulse, high in the first clk_in cycle in which clk_out is 0 after being 1.
REQ-012 SHALL have port halted  output  1  1 when the FSM is in HALTED.
REQ-013 SHALL have port busy  output  1  1 while a divisor change is pending.

Function
REQ-014 SHALL implement FSM states HALTED, RUNNING and STEP.
REQ-015 In HALTED, count SHALL be held at 0 and clk_out SHALL be held at 0.
REQ-016 In RUNNING or STEP, when count==H-1 the block SHALL clear count and toggle clk_out; otherwise it SHALL increment count.
REQ-017 HALTED SHALL go to RUNNING when run=1; run SHALL take precedence over a simultaneous step.
REQ-018 HALTED SHALL go to STEP when step=1 and run=0.
REQ-019 The first clk_out rise SHALL occur H clk_in cycles after the edge that leaves HALTED.
REQ-020 RUNNING SHALL go to HALTED only at a 1->0 toggle with run=0 sampled on that edge; a high phase SHALL never be truncated.
REQ-021 STEP SHALL go to HALTED at its first 1->0 toggle, regardless of run.
REQ-022 step pulses received in RUNNING or STEP SHALL be ignored.
REQ-023 On div_load=1, div_sel SHALL be captured into a pending register and busy SHALL be set on the next edge.
REQ-024 A further div_load while busy=1 SHALL overwrite the pending value.
REQ-025 The pending divisor SHALL become active H at the next 1->0 toggle, and busy SHALL clear on that edge, so the following low phase uses the new H.
REQ-026 In HALTED, a pending divisor SHALL be applied on the next edge, with busy high for exactly 1 cycle.
REQ-027 div_load and a 1->0 toggle on the same edge SHALL leave the old H applied and the new value pending.
REQ-028 H SHALL be fixed-width CNT_W, and count SHALL never exceed H-1.
REQ-029 clk_out high and low phases SHALL each be exactly H cycles when no divisor change is pending.

Reset
REQ-030 While reset=0 at a rising edge: state=HALTED, count=0, clk_out=0, clk_rise=0, clk_fall=0, halted=1, busy=0, active H=5, pending H=5.
REQ-031 Reset asserted mid-phase SHALL take effect on the next edge, with no completion of the current phase.

Verification
REQ-032 Release reset, run=1, no load -> clk_out 5 high / 5 low, period 10, one clk_rise pulse per 10 cycles, halted=0.
REQ-033 RUNNING, run=0 on 2nd cycle of a high phase -> high lasts the full 5 cycles, then clk_fall, halted=1, clk_out stays 0.
REQ-034 HALTED, single step pulse -> exactly one rise and one fall (5 high, 5 low), then halted=1; a second step during STEP produces no extra period.
REQ-035 RUNNING at H=5, div_load with sel=10 during a high phase -> busy=1 until the fall, next low phase 25 cycles, then 25/25 steady.
REQ-036 HALTED, div_load with sel=11, then run=1 -> busy high for 1 cycle, then clk_out 2/2.
REQ-037 RUNNING with clk_out=1, reset=0 for 1 cycle -> next edge clk_out=0, halted=1, H=5, busy=0.
